sar_adc_scheduler: RTL and testbench

Shares one 6-bit SAR converter among NCH analog channels.
- Arbitrates channel requests round-robin.
- Drives the analog mux select and the sample/hold enable, then pulses the SAR start.
- Waits for conversion done, with a timeout, and returns the tagged result over a valid/ready handshake.
- Sits between the channel front-ends and the SAR logic/comparator datapath.

---
 rtl/sar_sched_pkg.sv | 17 +
 rtl/sar_adc_scheduler_if.sv | 34 +++
 rtl/sar_adc_scheduler_rr_arbiter.sv | 32 +++
 rtl/sar_adc_scheduler.sv | 166 ++++++++++++++++
 tb/tb_sar_adc_scheduler.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sar_sched_pkg.sv
// Shared types and default sizing for the SAR ADC channel scheduler.
package sar_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        RESULT
    } state_t;

    localparam int DEF_NCH        = 4;
    localparam int DEF_CW         = 2;
    localparam int DEF_DW         = 6;
    localparam int DEF_SAMPLE_CYC = 4;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/sar_adc_scheduler_if.sv
// SAR-side control/data and tagged-result handshake of the scheduler.
interface sar_adc_scheduler_if
    import sar_sched_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int DW = DEF_DW
);

    logic [CW-1:0] mux_sel;
    logic          sh_en;
    logic          sar_start;
    logic          sar_done;
    logic [DW-1:0] sar_data;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [CW-1:0] res_chan;
    logic          res_err;

    modport master (
        output mux_sel, sh_en, sar_start,
        input  sar_done, sar_data,
        output res_valid, res_data, res_chan, res_err,
        input  res_ready
    );

    modport slave (
        input  mux_sel, sh_en, sar_start,
        output sar_done, sar_data,
        input  res_valid, res_data, res_chan, res_err,
        output res_ready
    );

endinterface

// File: rtl/sar_adc_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_gnt, wrapping.
module rr_arbiter
    import sar_sched_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  last_gnt,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  idx,
    output logic           any
);

    logic [CW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            pos = CW'((32'(last_gnt) + i) % NCH);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/sar_adc_scheduler.sv
// Shares one SAR converter among NCH channels: round-robin grant, sample,
// convert with timeout, and tagged result delivery over valid/ready.
module sar_adc_scheduler
    import sar_sched_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int CW         = DEF_CW,
    parameter int DW         = DEF_DW,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rest_n,
    input  logic                enable,
    input  logic [NCH-1:0]      req,
    output logic [NCH-1:0]      gnt,
    output logic                busy,
    sar_adc_scheduler_if.master bus
);

    localparam int CMAX = (SAMPLE_CYC > TIMEOUT) ? SAMPLE_CYC : TIMEOUT;
    localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_t          state, nstate;
    logic [CW-1:0]   chan_q, chan_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]   mux_q, mux_d;
    logic            sh_q, sh_d;
    logic            start_q, start_d;
    logic            rv_q, rv_d;
    logic [DW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   rc_q, rc_d;
    logic            re_q, re_d;
    logic            busy_q, busy_d;

    logic [NCH-1:0]  arb_gnt;
    logic [CW-1:0]   arb_idx;
    logic            arb_any;
    logic            sample_last, conv_last, done_hit;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req      (req),
        .last_gnt (last_q),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .any      (arb_any)
    );

    assign sample_last = (cnt_q == CNTW'(SAMPLE_CYC - 1));
    assign conv_last   = (cnt_q == CNTW'(TIMEOUT - 1));
    // The first CONVERT cycle (cnt 0) is the start pulse; done is ignored there.
    assign done_hit    = (cnt_q != '0) && bus.sar_done;

    always_ff @(posedge clk) begin
        if (!rest_n) begin
            state   <= IDLE;
            chan_q  <= '0;
            last_q  <= CW'(NCH - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            mux_q   <= '0;
            sh_q    <= 1'b0;
            start_q <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            rc_q    <= '0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= nstate;
            chan_q  <= chan_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            mux_q   <= mux_d;
            sh_q    <= sh_d;
            start_q <= start_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            rc_q    <= rc_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (enable && arb_any)     nstate = SAMPLE;
            SAMPLE:  if (sample_last)           nstate = CONVERT;
            CONVERT: if (done_hit || conv_last) nstate = RESULT;
            RESULT:  if (bus.res_ready)         nstate = IDLE;
            default:                            nstate = IDLE;
        endcase
    end

    // Next values of every registered output, so each output leaves a flop.
    always_comb begin
        chan_d  = chan_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        mux_d   = mux_q;
        sh_d    = sh_q;
        start_d = 1'b0;
        rv_d    = rv_q;
        rd_d    = rd_q;
        rc_d    = rc_q;
        re_d    = re_q;
        busy_d  = (nstate != IDLE);
        case (state)
            IDLE: begin
                if (nstate == SAMPLE) begin
                    chan_d = arb_idx;
                    gnt_d  = arb_gnt;
                    mux_d  = arb_idx;
                    sh_d   = 1'b1;
                    cnt_d  = '0;
                end
            end
            SAMPLE: begin
                if (nstate == CONVERT) begin
                    sh_d    = 1'b0;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONVERT: begin
                if (nstate == RESULT) begin
                    rv_d  = 1'b1;
                    rc_d  = chan_q;
                    rd_d  = done_hit ? bus.sar_data : '0;
                    re_d  = !done_hit;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (nstate == IDLE) begin
                    rv_d   = 1'b0;
                    last_d = chan_q;
                end
            end
            default: ;
        endcase
    end

    assign gnt           = gnt_q;
    assign busy          = busy_q;
    assign bus.mux_sel   = mux_q;
    assign bus.sh_en     = sh_q;
    assign bus.sar_start = start_q;
    assign bus.res_valid = rv_q;
    assign bus.res_data  = rd_q;
    assign bus.res_chan  = rc_q;
    assign bus.res_err   = re_q;

endmodule

// File: tb/tb_sar_adc_scheduler.sv
// Bench for sar_adc_scheduler: vector table, randomized ops against a
// transaction-level model, and hand sequences for reset corner cases.
module tb_sar_adc_scheduler;

    localparam int NCH = 4;
    localparam int SC  = 4;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rest_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       busy;
    int         cyc = 0;
    int         nvec = 0;
    int         nerr = 0;
    int         last = NCH - 1;

    sar_adc_scheduler_if #(.CW(2), .DW(6)) bus ();

    sar_adc_scheduler #(
        .NCH        (NCH),
        .CW         (2),
        .DW         (6),
        .SAMPLE_CYC (SC),
        .TIMEOUT    (TO)
    ) dut (
        .clk    (clk),
        .rest_n (rest_n),
        .enable (enable),
        .req    (req),
        .gnt    (gnt),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] r;
        int         dd;
        logic [5:0] d;
        int         rw;
        bit         spur;
        bit         enoff;
        int         ech;
        logic [5:0] ed;
        bit         ee;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first requesting channel after the last grant, wrapping.
    function automatic int rr_pick(input logic [3:0] r, input int lst);
        for (int i = 1; i <= NCH; i++) begin
            if (((r >> ((lst + i) % NCH)) & 4'b0001) != 4'b0000)
                return (lst + i) % NCH;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_gnt",       32'(gnt), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_mux_sel",   32'(bus.mux_sel), 32'd0);
        chk("rst_sh_en",     32'(bus.sh_en), 32'd0);
        chk("rst_sar_start", 32'(bus.sar_start), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data",  32'(bus.res_data), 32'd0);
        chk("rst_res_chan",  32'(bus.res_chan), 32'd0);
        chk("rst_res_err",   32'(bus.res_err), 32'd0);
    endtask

    // One full operation, starting at a negedge with the DUT in IDLE.
    // dd: sar_done offset from the sar_start cycle (valid range 1..TO-1).
    task automatic do_op(input logic [3:0] r, input int dd, input logic [5:0] d,
                         input int rw, input bit spur, input bit enoff,
                         input int ech, input logic [5:0] ed, input bit ee);
        logic [3:0] oh;
        bit         real_done;
        int         nconv;
        oh        = 4'b0001 << ech;
        real_done = (dd >= 1) && (dd <= TO - 1);
        nconv     = real_done ? dd + 1 : TO;

        chk("idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        req    = r;
        @(negedge clk);
        chk("gnt_onehot", 32'(gnt), 32'(oh));
        chk("sh_en_first", 32'(bus.sh_en), 32'd1);
        chk("mux_sel_sample", 32'(bus.mux_sel), 32'(ech));
        chk("busy_sample", 32'(busy), 32'd1);
        req = 4'($urandom);
        if (enoff) enable = 1'b0;
        for (int k = 2; k <= SC; k++) begin
            bus.sar_done = spur;
            bus.sar_data = ~d;
            @(negedge clk);
            chk("gnt_once", 32'(gnt), 32'd0);
            chk("sh_en_hold", 32'(bus.sh_en), 32'd1);
            chk("sar_start_early", 32'(bus.sar_start), 32'd0);
        end
        bus.sar_done = spur;
        bus.sar_data = ~d;
        @(negedge clk);
        chk("sar_start", 32'(bus.sar_start), 32'd1);
        chk("sh_en_convert", 32'(bus.sh_en), 32'd0);
        chk("mux_sel_convert", 32'(bus.mux_sel), 32'(ech));
        for (int k = 0; k < nconv; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("sar_start_once", 32'(bus.sar_start), 32'd0);
                chk("res_valid_early", 32'(bus.res_valid), 32'd0);
                chk("busy_convert", 32'(busy), 32'd1);
            end
            bus.sar_done = (real_done && k == dd) || (k == 0 && spur);
            bus.sar_data = (real_done && k == dd) ? d : ~d;
        end
        @(negedge clk);
        bus.sar_done = (dd == TO);
        bus.sar_data = ~d;
        for (int w = 0; w <= rw; w++) begin
            if (w > 0) begin
                @(negedge clk);
                bus.sar_done = 1'b0;
            end
            chk("res_valid", 32'(bus.res_valid), 32'd1);
            chk("res_data", 32'(bus.res_data), 32'(ed));
            chk("res_chan", 32'(bus.res_chan), 32'(ech));
            chk("res_err", 32'(bus.res_err), 32'(ee));
            chk("gnt_in_result", 32'(gnt), 32'd0);
            bus.res_ready = (w == rw);
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.sar_done  = 1'b0;
        chk("valid_drop", 32'(bus.res_valid), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        last = ech;
        if (enoff) begin
            req = 4'b1111;
            repeat (3) begin
                @(negedge clk);
                chk("no_gnt_disabled", 32'(gnt), 32'd0);
                chk("idle_disabled", 32'(busy), 32'd0);
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0100,  7, 6'h2A,  0, 1'b0, 1'b0, 2, 6'h2A, 1'b0};
        tbl[1] = '{4'b1111,  3, 6'h11,  0, 1'b0, 1'b0, 3, 6'h11, 1'b0};
        tbl[2] = '{4'b1111,  1, 6'h05,  0, 1'b0, 1'b0, 0, 6'h05, 1'b0};
        tbl[3] = '{4'b1111, 15, 6'h3F,  0, 1'b0, 1'b0, 1, 6'h3F, 1'b0};
        tbl[4] = '{4'b1111,  0, 6'h12,  0, 1'b0, 1'b0, 2, 6'h00, 1'b1};
        tbl[5] = '{4'b1010, 16, 6'h2C,  0, 1'b0, 1'b0, 3, 6'h00, 1'b1};
        tbl[6] = '{4'b1111,  4, 6'h1B, 10, 1'b0, 1'b0, 0, 6'h1B, 1'b0};
        tbl[7] = '{4'b0011,  5, 6'h33,  0, 1'b1, 1'b1, 1, 6'h33, 1'b0};
        tbl[8] = '{4'b1001,  2, 6'h0E,  0, 1'b0, 1'b0, 3, 6'h0E, 1'b0};
        tbl[9] = '{4'b0110,  6, 6'h20,  0, 1'b0, 1'b0, 1, 6'h20, 1'b0};

        rest_n        = 1'b0;
        enable        = 1'b0;
        req           = 4'b0000;
        bus.sar_done  = 1'b0;
        bus.sar_data  = 6'h00;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rest_n = 1'b1;
        req    = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            chk("no_gnt_enable_low", 32'(gnt), 32'd0);
            chk("idle_enable_low", 32'(busy), 32'd0);
        end
        req = 4'b0000;
        enable = 1'b1;
        @(negedge clk);
        chk("no_gnt_no_req", 32'(gnt), 32'd0);

        for (int v = 0; v < 10; v++)
            do_op(tbl[v].r, tbl[v].dd, tbl[v].d, tbl[v].rw, tbl[v].spur,
                  tbl[v].enoff, tbl[v].ech, tbl[v].ed, tbl[v].ee);

        for (int n = 0; n < 12; n++) begin
            logic [3:0] r;
            logic [5:0] d;
            int         dd;
            int         ech;
            bit         ok;
            r   = 4'($urandom_range(1, 15));
            d   = 6'($urandom);
            dd  = int'($urandom_range(0, TO + 1));
            ech = rr_pick(r, last);
            ok  = (dd >= 1) && (dd <= TO - 1);
            do_op(r, dd, d, int'($urandom_range(0, 3)), 1'($urandom), 1'b0,
                  ech, ok ? d : 6'h00, !ok);
        end

        // Reset in the middle of CONVERT with a done pulse in the same cycle.
        enable = 1'b1;
        req    = 4'b1111;
        repeat (SC + 3) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rest_n       = 1'b0;
        bus.sar_done = 1'b1;
        bus.sar_data = 6'h15;
        @(negedge clk);
        check_reset_outputs();
        rest_n       = 1'b1;
        bus.sar_done = 1'b0;
        last         = NCH - 1;
        do_op(4'b1111, 3, 6'h3C, 0, 1'b0, 1'b0, 0, 6'h3C, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
